// File: rtl/uart_tx_arbiter_if.sv
// Request and transmitter-side bus of the UART TX arbiter.
// Ports: req_valid/req_data/req_ready (4 byte requesters), cfg_par_en/cfg_par_typ (per-requester parity),
// tx_* (launch bus to the UART transmitter), grant_id/active/timeout_err (status).
// master = the arbiter, slave = the requesters plus transmitter environment.
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  cfg_par_en;
  logic [3:0]  cfg_par_typ;
  logic        tx_busy;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        tx_par_en;
  logic        tx_par_typ;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  modport master (
    input  req_valid, req_data, cfg_par_en, cfg_par_typ, tx_busy,
    output req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ,
           grant_id, active, timeout_err
  );

  modport slave (
    output req_valid, req_data, cfg_par_en, cfg_par_typ, tx_busy,
    input  req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ,
           grant_id, active, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from 4 requesters into one UART transmitter.
// Latency: accept at t, launch strobe at t+1; a frame holds the arbiter until tx_busy falls or the launch times out.
// Backpressure: one-hot req_ready only while idle and the transmitter is not busy; other requesters are held off.
// Ports: clk, rst (synchronous, active-high), bus (uart_tx_arbiter_if.master).
module uart_tx_arbiter #(
  parameter int TIMEOUT = 4
) (
  input logic            clk,
  input logic            rst,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  last_grant;
  logic [2:0]  wait_cnt;
  logic [7:0]  data_q;
  logic        par_en_q;
  logic        par_typ_q;
  logic [1:0]  grant_q;
  logic        timeout_q;

  logic [1:0]  winner;
  logic        found;
  logic        accept;
  logic        time_up;

  // Search starts just past the previous winner; k = 4 wraps back onto it.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && bus.req_valid[last_grant + 2'(k)]) begin
        found  = 1'b1;
        winner = last_grant + 2'(k);
      end
    end
  end

  // A busy transmitter in IDLE is carrying someone else's frame: do not accept.
  assign accept  = (state == IDLE) && !rst && !bus.tx_busy && found;
  assign time_up = (wait_cnt >= WAIT_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (accept) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)  state_nxt = WAIT_DONE;
        else if (time_up) state_nxt = IDLE;
      end
      WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      wait_cnt   <= 3'd0;
      data_q     <= 8'd0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      grant_q    <= 2'd0;
      timeout_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      timeout_q <= (state == WAIT_BUSY) && !bus.tx_busy && time_up;
      // Held at zero outside WAIT_BUSY, so it is clear on entry.
      if (state != WAIT_BUSY)   wait_cnt <= 3'd0;
      else if (wait_cnt != 3'd7) wait_cnt <= wait_cnt + 3'd1;
      if (accept) begin
        data_q     <= bus.req_data[{winner, 3'b000} +: 8];
        par_en_q   <= bus.cfg_par_en[winner];
        par_typ_q  <= bus.cfg_par_typ[winner];
        grant_q    <= winner;
        last_grant <= winner;
      end
    end
  end

  assign bus.req_ready     = accept ? (4'b0001 << winner) : 4'b0000;
  assign bus.tx_data_valid = (state == LAUNCH);
  assign bus.active        = (state != IDLE);
  assign bus.timeout_err   = timeout_q;
  // The transmitter samples these live during the frame; only an accept changes them.
  assign bus.tx_p_data     = data_q;
  assign bus.tx_par_en     = par_en_q;
  assign bus.tx_par_typ    = par_typ_q;
  assign bus.grant_id      = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int TB_TIMEOUT = 4;

  logic clk;
  logic rst;
  uart_tx_arbiter_if ifc();

  uart_tx_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (timestamp based), checked every cycle ----------------
  int        cyc = 0;
  bit        m_on = 0;
  int        m_idle_from = 0;
  int        m_acc = -10;
  int        m_wb = 1 << 30;
  int        m_to = -10;
  bit        m_got = 0;
  int        m_last = 3;
  logic [7:0] m_data = 8'd0;
  logic      m_pe = 1'b0;
  logic      m_pt = 1'b0;
  logic [1:0] m_gid = 2'd0;
  int        glog[$];
  int        tcyc[$];
  int        toq[$];
  int        rdy_active = 0;

  always @(negedge clk) begin
    bit         idle;
    bit         acc;
    int         w;
    logic [3:0] e_ready;
    if (rst) begin
      m_on = 1; m_idle_from = cyc + 1; m_last = 3; m_acc = -10; m_to = -10;
      m_wb = 1 << 30; m_got = 0; m_data = 8'd0; m_pe = 0; m_pt = 0; m_gid = 2'd0;
    end else if (m_on) begin
      idle = (cyc >= m_idle_from);
      acc = 0; w = 0; e_ready = 4'b0000;
      if (idle && !ifc.tx_busy && (ifc.req_valid != 4'b0000)) begin
        for (int k = 1; k <= 4; k++) begin
          if (!acc && ifc.req_valid[(m_last + k) % 4]) begin
            acc = 1; w = (m_last + k) % 4;
          end
        end
        e_ready = 4'b0001 << w;
      end
      chk("req_ready", ifc.req_ready, e_ready);
      chk("tx_data_valid", ifc.tx_data_valid, (cyc == m_acc + 1));
      chk("active", ifc.active, !idle);
      chk("timeout_err", ifc.timeout_err, (cyc == m_to));
      chk("tx_p_data", ifc.tx_p_data, m_data);
      chk("tx_par_en", ifc.tx_par_en, m_pe);
      chk("tx_par_typ", ifc.tx_par_typ, m_pt);
      chk("grant_id", ifc.grant_id, m_gid);
      if (ifc.tx_data_valid) begin glog.push_back(int'(ifc.grant_id)); tcyc.push_back(cyc); end
      if (ifc.timeout_err) toq.push_back(cyc);
      if (ifc.active && ifc.req_ready != 4'b0000) rdy_active++;
      if (acc) begin
        m_data = ifc.req_data[8*w +: 8]; m_pe = ifc.cfg_par_en[w]; m_pt = ifc.cfg_par_typ[w];
        m_gid = 2'(w); m_last = w; m_acc = cyc; m_wb = cyc + 2; m_got = 0; m_idle_from = 1 << 30;
      end else if (!idle && cyc >= m_wb) begin
        if (m_got) begin
          if (!ifc.tx_busy) m_idle_from = cyc + 1;
        end else if (ifc.tx_busy) begin
          m_got = 1;
        end else if (cyc - m_wb == TB_TIMEOUT - 1) begin
          m_idle_from = cyc + 1; m_to = cyc + 1;
        end
      end
    end
    cyc++;
  end

  // ---------------- transmitter emulation, driven from the stimulus thread ----------------
  bit          xmode = 0;   // 1: tx_busy forced to xforce
  bit          xforce = 0;
  int          x_delay = 0;
  int          x_bit = -1;
  int          x_len = 10;
  logic [10:0] line = 11'd0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (xmode) begin
      ifc.tx_busy = xforce;
    end else if (rst) begin
      x_bit = -1; x_delay = 0; ifc.tx_busy = 1'b0;
    end else if (x_bit >= 0) begin
      x_bit++;
      if (x_bit >= x_len) begin
        x_bit = -1; ifc.tx_busy = 1'b0;
      end else if (x_bit <= 8) begin
        line[x_bit] = ifc.tx_p_data[x_bit-1];
      end else if (x_bit == 9 && x_len == 11) begin
        line[x_bit] = (^ifc.tx_p_data) ^ ifc.tx_par_typ;
      end else begin
        line[x_bit] = 1'b1;
      end
    end else if (x_delay > 0) begin
      x_delay--;
      if (x_delay == 0) begin
        x_bit = 0; ifc.tx_busy = 1'b1; line[0] = 1'b0; x_len = ifc.tx_par_en ? 11 : 10;
      end
    end else if (ifc.tx_data_valid) begin
      x_delay = 2;
    end
  endtask

  task automatic do_reset();
    xmode = 0; ifc.tx_busy = 1'b0; ifc.req_valid = 4'b0000;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    glog.delete(); tcyc.delete(); toq.delete();
  endtask

  task automatic grab(input int p, input string nm);
    int n;
    #1;
    for (n = 0; n < 20 && !ifc.req_ready[p]; n++) tick();
    chk(nm, ifc.req_ready[p], 1'b1);
    tick();
    ifc.req_valid[p] = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int budget, input string nm);
    for (int n = 0; n < budget && ifc.tx_busy !== val; n++) tick();
    chk(nm, ifc.tx_busy, val);
  endtask

  task automatic wait_grants(input int k, input int budget, input string nm);
    for (int n = 0; n < budget && glog.size() < k; n++) tick();
    chk(nm, (glog.size() >= k), 1'b1);
  endtask

  function automatic int gl(input int i);
    return (glog.size() > i) ? glog[i] : -1;
  endfunction

  initial begin
    int blocked;
    int exp_order[5];
    rst = 1'b1;
    ifc.req_valid = 4'b0000; ifc.req_data = 32'd0;
    ifc.cfg_par_en = 4'b0000; ifc.cfg_par_typ = 4'b0000; ifc.tx_busy = 1'b0;

    // Reset state
    do_reset();
    #1;
    chk("rst_active", ifc.active, 1'b0);
    chk("rst_grant", ifc.grant_id, 2'd0);
    chk("rst_data", ifc.tx_p_data, 8'h00);

    // Single request on port 2: 0xA5, even parity
    ifc.req_data = 32'h00A5_0000; ifc.cfg_par_en = 4'b0100; ifc.cfg_par_typ = 4'b0000;
    line = 11'd0;
    ifc.req_valid = 4'b0100;
    grab(2, "single_ready");
    chk("single_launch", ifc.tx_data_valid, 1'b1);
    chk("single_launch_data", ifc.tx_p_data, 8'hA5);
    wait_busy(1'b1, 10, "single_busy_rise");
    wait_busy(1'b0, 20, "single_busy_fall");
    chk("single_line", line, {1'b1, 1'b0, 8'hA5, 1'b0});
    chk("single_hold_data", ifc.tx_p_data, 8'hA5);
    chk("single_hold_par", {ifc.tx_par_en, ifc.tx_par_typ}, 2'b10);
    chk("single_grant", ifc.grant_id, 2'd2);
    for (int i = 0; i < 3; i++) tick();

    // All four valid continuously from reset
    do_reset();
    ifc.req_data = 32'h4433_2211; ifc.cfg_par_en = 4'b1010; ifc.cfg_par_typ = 4'b1100;
    ifc.req_valid = 4'b1111;
    wait_grants(5, 200, "rr_progress");
    ifc.req_valid = 4'b0000;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), gl(i), exp_order[i]);
    chk("rr_no_accept_active", rdy_active, 0);
    wait_busy(1'b0, 30, "rr_drain");
    for (int i = 0; i < 3; i++) tick();

    // Dead transmitter: timeout then next port
    do_reset();
    xmode = 1; xforce = 0;
    ifc.req_valid = 4'b0011;
    wait_grants(2, 40, "dead_progress");
    ifc.req_valid = 4'b0000;
    chk("dead_first", gl(0), 0);
    chk("dead_next", gl(1), 1);
    chk("dead_pulse_offset", (toq.size() > 0 && tcyc.size() > 0) ? toq[0] - tcyc[0] : -1, 5);
    for (int i = 0; i < 12; i++) tick();

    // Reset during WAIT_DONE
    do_reset();
    ifc.req_valid = 4'b0100;
    grab(2, "wd_ready");
    wait_busy(1'b1, 10, "wd_busy_rise");
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("wd_rst_active", ifc.active, 1'b0);
    chk("wd_rst_launch", ifc.tx_data_valid, 1'b0);
    chk("wd_rst_err", ifc.timeout_err, 1'b0);
    chk("wd_rst_data", ifc.tx_p_data, 8'h00);
    chk("wd_rst_par", {ifc.tx_par_en, ifc.tx_par_typ}, 2'b00);
    chk("wd_rst_grant", ifc.grant_id, 2'd0);
    glog.delete();
    ifc.req_valid = 4'b1111;
    wait_grants(1, 10, "wd_regrant");
    ifc.req_valid = 4'b0000;
    chk("wd_port0_first", gl(0), 0);
    wait_busy(1'b1, 10, "wd2_busy_rise");
    wait_busy(1'b0, 20, "wd2_busy_fall");
    for (int i = 0; i < 3; i++) tick();

    // Foreign busy in IDLE blocks accept
    do_reset();
    xmode = 1; xforce = 1; ifc.tx_busy = 1'b1;
    ifc.req_valid = 4'b0010;
    #1;
    blocked = 0;
    for (int i = 0; i < 5; i++) begin
      if (ifc.req_ready != 4'b0000) blocked++;
      tick();
    end
    chk("busy_block", blocked, 0);
    xmode = 0; ifc.tx_busy = 1'b0;
    #1;
    chk("busy_release", ifc.req_ready, 4'b0010);
    tick();
    ifc.req_valid = 4'b0000;
    wait_busy(1'b1, 10, "bl_busy_rise");
    wait_busy(1'b0, 20, "bl_busy_fall");
    for (int i = 0; i < 3; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4, meaning max cycles in WAIT_BUSY before abort.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  4  per-requester byte-available flags.
REQ-005 SHALL have port req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-006 SHALL have port req_ready  output  4  one-hot accept strobe; byte taken when req_valid[i] & req_ready[i].
REQ-007 SHALL have port cfg_par_en  input  4  per-requester parity enable.
REQ-008 SHALL have port cfg_par_typ  input  4  per-requester parity type, 1 = odd, 0 = even.
REQ-009 SHALL have port tx_busy  input  1  BUSY from the UART transmitter.
REQ-010 SHALL have port tx_p_data  output  8  byte to the transmitter.
REQ-011 SHALL have port tx_data_valid  output  1  single-cycle launch strobe to the transmitter.
REQ-012 SHALL have port tx_par_en  output  1  parity enable to the transmitter.
REQ-013 SHALL have port tx_par_typ  output  1  parity type to the transmitter.
REQ-014 SHALL have port grant_id  output  2  index of the requester owning the current frame.
REQ-015 SHALL have port active  output  1  high in every state except IDLE.
REQ-016 SHALL have port timeout_err  output  1  one-cycle pulse on launch abort.

Function
REQ-017 SHALL implement FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE: if any req_valid is set, SHALL pick a winner round-robin, starting at (last_grant+1) mod 4 and ascending with wrap.
REQ-019 In IDLE, req_ready[w] SHALL be high for exactly one cycle, combinationally from req_valid; requesters SHALL NOT derive req_valid from req_ready.
REQ-020 On accept, SHALL register byte, cfg_par_en[w], cfg_par_typ[w], grant_id = w and last_grant = w, then go to LAUNCH.
REQ-021 req_ready SHALL be all-zero outside IDLE; valid on other ports is held off, not dropped.
REQ-022 LAUNCH: tx_data_valid SHALL be 1 for exactly this one cycle; next state is WAIT_BUSY.
REQ-023 WAIT_BUSY: tx_busy = 1 SHALL move to WAIT_DONE.
REQ-024 WAIT_BUSY: TIMEOUT cycles without tx_busy SHALL pulse timeout_err for 1 cycle and return to IDLE.
REQ-025 The WAIT_BUSY cycle counter SHALL be 3 bits, saturating, and cleared on entry.
REQ-026 WAIT_DONE: tx_busy = 0 SHALL return to IDLE on the next edge.
REQ-027 tx_p_data, tx_par_en and tx_par_typ SHALL hold stable from LAUNCH until IDLE is re-entered, because the transmitter reads data bits live during the frame.
REQ-028 In IDLE, tx_p_data, tx_par_en and tx_par_typ SHALL retain their last values; grant_id SHALL retain the last winner.
REQ-029 Cycle budget: accept at t, LAUNCH t+1, transmitter BUSY expected at t+3; next accept no earlier than 1 cycle after tx_busy falls.
REQ-030 Requester valid deasserting outside IDLE SHALL have no effect; only the accept cycle matters.
REQ-031 tx_busy high while in IDLE (foreign or stale frame) SHALL block accept until tx_busy = 0.

Reset
REQ-032 rst SHALL force IDLE and set last_grant = 3, so port 0 has first priority.
REQ-033 rst SHALL zero tx_p_data, tx_par_en, tx_par_typ, grant_id and the WAIT_BUSY counter.
REQ-034 rst SHALL deassert req_ready, tx_data_valid, active and timeout_err.
REQ-035 rst mid-frame SHALL abandon the frame without an error pulse; the transmitter shares rst.

Verification
REQ-036 Single request: port 2 valid with 0xA5, par_en = 1, typ = 0 -> ready[2] 1 cycle; tx_data_valid 1 cycle later; tx_p_data = 0xA5, par_en = 1, par_typ = 0 held until tx_busy falls; line shows start, A5 LSB-first, parity 0, stop.
REQ-037 All four valid continuously -> grant order 0, 1, 2, 3, 0; exactly one tx_data_valid per frame; no accept while active.
REQ-038 Dead transmitter (tx_busy tied 0) -> timeout_err pulses 4 cycles after entering WAIT_BUSY; FSM back in IDLE; next port granted.
REQ-039 rst asserted during WAIT_DONE -> next cycle all outputs at reset values; after release, port 0 wins first.
REQ-040 tx_busy held 1 in IDLE with port 1 valid -> no req_ready until tx_busy drops; then accept within 1 cycle.
